// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared CPU fetch definitions (state encoding, reset PC default)
package fetch_unit_pkg;
   localparam int FETCH_ADDR_W = 16;
   localparam logic [15:0] FETCH_RESET_PC = 16'h0000;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} fetch_state_e;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with redirect load and wrapping increment
module fetch_pc_reg
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_W = FETCH_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);
   // load beats increment; increment wraps naturally at the register width
   always_ff @(posedge clk) begin
      if (reset) pc <= RESET_PC;
      else if (load) pc <= load_addr;
      else if (inc) pc <= pc + ADDR_W'(1);
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-port instruction fetch FSM with redirect and decoder handshake
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_W = FETCH_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   input  logic [15:0]       mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   output logic [15:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready
);
   fetch_state_e state, state_nxt;
   logic [ADDR_W-1:0] pc;
   logic pc_load, pc_inc, capture;
   fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
      .clk(clk),
      .reset(reset),
      .load(pc_load),
      .load_addr(redirect_addr),
      .inc(pc_inc),
      .pc(pc)
   );
   // next state and strobes; a redirect outside IDLE restarts at REQ and drops any in-flight read
   always_comb begin
      pc_load = redirect && state != IDLE;
      pc_inc = state == VALID && instr_ready && !redirect;
      capture = state == WAIT && !redirect;
      state_nxt = (state == IDLE) ? REQ :
                  (state == REQ) ? (stall ? REQ : WAIT) :
                  (state == WAIT) ? VALID :
                  (instr_ready ? REQ : VALID);
      if (pc_load) state_nxt = REQ;
      mem_rd_en = state == REQ && !stall;
      mem_addr = pc;
      instr_valid = state == VALID;
   end
   // state register and instruction capture at the end of WAIT
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         instr <= 16'h0000;
         instr_pc <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            instr <= mem_rdata;
            instr_pc <= pc;
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomised checks of fetch_unit against a transaction-level model
module tb_fetch_unit;
   logic clk = 1'b0, reset = 1'b1, stall = 1'b0, redirect = 1'b0, instr_ready = 1'b0;
   logic [15:0] redirect_addr = 16'h0000, mem_rdata = 16'h0000;
   logic [15:0] mem_addr, instr, instr_pc;
   logic mem_rd_en, instr_valid;
   logic [15:0] mem [0:65535];
   int n_cmp = 0, n_bad = 0;
   bit armed = 0, idle = 0, owe = 0, inflight = 0, have = 0;
   logic [15:0] npc = 16'h0000, h_pc = 16'h0000, h_instr = 16'h0000;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .redirect(redirect),
      .redirect_addr(redirect_addr),
      .mem_rdata(mem_rdata),
      .mem_addr(mem_addr),
      .mem_rd_en(mem_rd_en),
      .instr(instr),
      .instr_pc(instr_pc),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready)
   );

   // block RAM port A: data one cycle after the request
   always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // model: a fetch is owed, issued, returned, then held until accepted
   always @(negedge clk) begin
      if (armed) begin
         chk("rd_en", mem_rd_en, owe && !stall);
         chk("mem_addr", mem_addr, npc);
         chk("valid", instr_valid, have);
         if (have) begin
            chk("instr", instr, h_instr);
            chk("instr_pc", instr_pc, h_pc);
         end
      end
      if (reset) begin
         armed = 1; idle = 1; owe = 0; inflight = 0; have = 0; npc = 16'h0000;
      end else if (idle) begin
         idle = 0; owe = 1;
      end else if (redirect) begin
         npc = redirect_addr; owe = 1; inflight = 0; have = 0;
      end else if (inflight) begin
         inflight = 0; have = 1; h_pc = npc; h_instr = mem[npc];
      end else if (owe && !stall) begin
         owe = 0; inflight = 1;
      end else if (have && instr_ready) begin
         have = 0; owe = 1; npc = npc + 16'd1;
      end
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 40503 + 7);
      mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
      tick(2);
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_addr", mem_addr, 16'h0000);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_ipc", instr_pc, 16'h0000);
      reset = 0; instr_ready = 1;
      tick(1);
      chk("first_rd_en", mem_rd_en, 1);
      chk("first_addr", mem_addr, 16'h0000);
      tick(2);
      chk("i0_valid", instr_valid, 1);
      chk("i0_instr", instr, 16'h1111);
      chk("i0_pc", instr_pc, 16'h0000);
      tick(1);
      chk("gap_valid", instr_valid, 0);
      chk("gap_addr", mem_addr, 16'h0001);
      tick(2);
      chk("i1_instr", instr, 16'h2222);
      chk("i1_pc", instr_pc, 16'h0001);
      tick(3);
      chk("i2_valid", instr_valid, 1);
      chk("i2_instr", instr, 16'h3333);
      chk("i2_pc", instr_pc, 16'h0002);
      stall = 1;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("stall_rd_en", mem_rd_en, 0);
         chk("stall_addr", mem_addr, 16'h0003);
      end
      stall = 0;
      #1;
      chk("unstall_rd_en", mem_rd_en, 1);
      chk("unstall_addr", mem_addr, 16'h0003);
      instr_ready = 0;
      tick(1);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("hold_valid", instr_valid, 1);
         chk("hold_pc", instr_pc, 16'h0003);
         chk("hold_addr", mem_addr, 16'h0003);
      end
      instr_ready = 1;
      tick(1);
      chk("adv_addr", mem_addr, 16'h0004);
      chk("adv_valid", instr_valid, 0);
      tick(1);
      redirect = 1; redirect_addr = 16'h0040;
      tick(1);
      redirect = 0;
      #1;
      chk("rdw_valid", instr_valid, 0);
      chk("rdw_addr", mem_addr, 16'h0040);
      tick(1);
      chk("rdw_valid2", instr_valid, 0);
      tick(1);
      chk("rdw_ipc", instr_pc, 16'h0040);
      redirect = 1; redirect_addr = 16'h0010;
      tick(1);
      redirect = 0;
      tick(2);
      chk("at10_pc", instr_pc, 16'h0010);
      redirect = 1; redirect_addr = 16'h0100;
      tick(1);
      redirect = 0;
      #1;
      chk("prio_addr", mem_addr, 16'h0100);
      chk("prio_valid", instr_valid, 0);
      redirect = 1; redirect_addr = 16'hFFFF;
      tick(1);
      redirect = 0;
      tick(2);
      chk("ffff_pc", instr_pc, 16'hFFFF);
      tick(1);
      chk("wrap_addr", mem_addr, 16'h0000);
      tick(2);
      chk("wrap_instr", instr, 16'h1111);
      reset = 1; redirect = 1; redirect_addr = 16'h0077; stall = 1;
      tick(1);
      stall = 0;
      #1;
      chk("vrst_valid", instr_valid, 0);
      chk("vrst_rd_en", mem_rd_en, 0);
      chk("vrst_addr", mem_addr, 16'h0000);
      chk("vrst_instr", instr, 16'h0000);
      chk("vrst_ipc", instr_pc, 16'h0000);
      reset = 0; redirect_addr = 16'h0055;
      tick(1);
      redirect = 0;
      #1;
      chk("idle_redir_addr", mem_addr, 16'h0000);
      tick(1);
      reset = 1;
      tick(1);
      chk("wrst_valid", instr_valid, 0);
      chk("wrst_instr", instr, 16'h0000);
      reset = 0;
      tick(3);
      chk("post_valid", instr_valid, 1);
      chk("post_instr", instr, 16'h1111);
      for (int i = 0; i < 300; i++) begin
         stall = $urandom_range(0, 3) == 0;
         instr_ready = $urandom_range(0, 1) == 1;
         redirect = $urandom_range(0, 15) == 0;
         redirect_addr = 16'($urandom);
         tick(1);
      end
      redirect = 0;
      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, address of the first instruction fetched after reset.
REQ-002 Parameter ADDR_W, default 16, width of the program counter and memory address.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  port A of the block RAM is claimed by a load/store this cycle; no fetch request is issued.
REQ-006 redirect  input  1  branch/jump taken; discard the current fetch and restart at redirect_addr.
REQ-007 redirect_addr  input  ADDR_W  target address for a redirect.
REQ-008 mem_rdata  input  16  port A read data from block RAM, valid one cycle after the request.
REQ-009 mem_addr  output  ADDR_W  port A read address, equal to the current PC.
REQ-010 mem_rd_en  output  1  port A read request strobe.
REQ-011 instr  output  16  captured instruction word, held stable while instr_valid is high.
REQ-012 instr_pc  output  ADDR_W  address from which instr was fetched.
REQ-013 instr_valid  output  1  instr is valid for the decoder.
REQ-014 instr_ready  input  1  decoder accepts instr this cycle.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, REQ, WAIT and VALID.
REQ-016 IDLE: outputs inactive; always transition to REQ on the next cycle.
REQ-017 REQ with stall=0: drive mem_rd_en=1 and mem_addr=PC, then go to WAIT.
REQ-018 REQ with stall=1: drive mem_rd_en=0 and remain in REQ.
REQ-019 WAIT: capture mem_rdata into instr and PC into instr_pc, then go to VALID; stall is ignored in this state.
REQ-020 VALID: hold instr_valid=1; on instr_ready=1, set PC to PC+1 and go to REQ; otherwise hold instr, instr_pc and PC unchanged.
REQ-021 PC increment SHALL wrap modulo 2^ADDR_W (16'hFFFF+1 gives 16'h0000), with no flag.
REQ-022 A redirect in any non-IDLE state SHALL, on the next edge, load PC with redirect_addr, clear instr_valid and go to REQ.
REQ-023 Read data returning in the cycle after a redirect SHALL be discarded.
REQ-024 When redirect and instr_ready are both high, redirect SHALL take priority and PC+1 SHALL NOT occur.
REQ-025 Redirect during IDLE SHALL be ignored.
REQ-026 Fetch latency SHALL be 2 cycles from the REQ-state edge to instr_valid=1 when there is no stall; sustained throughput SHALL be one instruction per 3 cycles.
REQ-027 mem_rd_en SHALL be high only in REQ with stall=0.

Reset
REQ-028 On a reset-high edge: state=IDLE, PC=RESET_PC, instr=16'h0000, instr_pc=16'h0000, instr_valid=0, mem_rd_en=0, mem_addr=RESET_PC.
REQ-029 Reset SHALL take priority over redirect, stall and instr_ready, including mid-fetch in WAIT or VALID.
REQ-030 An in-flight read abandoned by reset SHALL NOT be captured.

Structure
REQ-031 State encoding (2-bit enum) and the RESET_PC default SHALL reside in the shared CPU package.
REQ-032 The PC register with its increment/redirect load SHALL be one sub-module, fetch_pc_reg; the FSM and instruction capture SHALL stay in fetch_unit.

Verification
REQ-033 Reset release, no stall, instr_ready=1 always, memory[0..2]=16'h1111/2222/3333 -> instr_valid pulses every 3 cycles with instr/instr_pc = 1111/0, 2222/1, 3333/2.
REQ-034 stall=1 for 4 cycles while in REQ -> mem_rd_en=0 throughout; fetch of the same address occurs on the first cycle with stall=0; no address is skipped.
REQ-035 instr_ready=0 for 5 cycles in VALID -> instr and instr_pc stable, PC unchanged; advances only after the ready cycle.
REQ-036 redirect=1 with redirect_addr=16'h0040 while in WAIT -> stale data dropped, instr_valid stays 0, next mem_addr=16'h0040, next instr_pc=16'h0040.
REQ-037 Redirect and instr_ready both high in VALID at PC=16'h0010, redirect_addr=16'h0100 -> next mem_addr=16'h0100, not 16'h0011.
REQ-038 PC=16'hFFFF accepted -> next mem_addr=16'h0000; reset asserted in VALID -> next cycle all outputs at their reset values.
